fu_issue_arbiter: RTL
=====================

FU_ISSUE_ARBITER -- requirements
Module: fu_issue_arbiter

Interface
REQ-001 SHALL have port: clk  in  1  sole clock, rising edge.
REQ-002 SHALL have port: reset  in  1  asynchronous, active-low; 0 = in reset.
REQ-003 SHALL have port: req_v  in  2  per-requester instruction valid (bit i = requester i).
REQ-004 SHALL have port: req_unit  in  4  2 bits per requester; 0 ALU, 1 ADD, 2 MUL, 3 illegal.
REQ-005 SHALL have port: req_delay  in  6  3 bits per requester; writeback latency 0..7, where 0 = no writeback.
REQ-006 SHALL have port: add_ready  in  1  ADD unit accepts an op this cycle.
REQ-007 SHALL have port: mul_ready  in  1  MUL unit accepts an op this cycle.
REQ-008 SHALL have port: grant  out  2  one-hot or zero; combinational grant to requester i.
REQ-009 SHALL have port: issue_v  out  1  an op is dispatched this cycle (OR of grant).
REQ-010 SHALL have port: issue_unit  out  2  unit of the granted op.
REQ-011 SHALL have port: issue_delay  out  3  delay of the granted op.
REQ-012 SHALL have port: issue_src  out  1  index of the granted requester.
REQ-013 SHALL have port: wb_v  out  1  registered; the shared result bus is written this cycle.
REQ-014 SHALL have port: wb_src  out  1  registered; requester owning the current writeback.

Function
REQ-015 Requester i SHALL be eligible iff req_v[i], unit != 3, its writeback slot is free, and its unit is ready.
REQ-016 Slot rule: delay d>0 requested in cycle t SHALL be free iff no earlier grant has a writeback in cycle t+d; d=0 is always free.
REQ-017 Unit readiness: ALU always ready; ADD needs add_ready; MUL needs mul_ready and mul_busy==0.
REQ-018 At most one grant per cycle; grant, issue_* SHALL be combinational in the same cycle as the request.
REQ-019 Both eligible: grant requester rr; one eligible: grant it; none: grant=0, issue_*=0.
REQ-020 After any grant to requester g, rr SHALL become ~g at the next edge; with no grant, rr holds.
REQ-021 A grant with delay d>0 in cycle t SHALL produce wb_v=1, wb_src=g in cycle t+d exactly, for one cycle.
REQ-022 Reservation tracker: 7-entry valid+owner shift register advancing once per cycle, with a writeback in at most one slot per cycle.
REQ-023 MUL grant with delay d in cycle t SHALL hold mul_busy in t+1..t+d-1; a MUL becomes grantable again in t+d. d<=1 causes no busy time.
REQ-024 Grants to an ineligible requester SHALL NOT occur even if rr points to it; rr is not advanced by a blocked request.

Reset
REQ-025 While reset=0: grant=0, issue_v=0, issue_*=0, wb_v=0, wb_src=0, asynchronously.
REQ-026 Reset SHALL clear all reservations, owners, mul_busy, and set rr=0; in-flight writebacks are discarded and never appear after release.
REQ-027 First grant is possible in the first cycle with reset=1.

Structure
REQ-028 Package fu_sched_pkg SHALL hold the unit encoding (ALU/ADD/MUL/ILLEGAL), NUM_REQ=2, MAX_DELAY=7.
REQ-029 Sub-module wb_slot_tracker SHALL implement the reservation/owner shift register, the slot-free query, and the wb_v/wb_src output.
REQ-030 The arbitration, readiness check and mul_busy counter SHALL reside in fu_issue_arbiter.

Verification
REQ-031 req0 ADD d=3, add_ready=1, cycle 5 -> grant=01 in cycle 5; wb_v=1, wb_src=0 in cycle 8 only.
REQ-032 Both requesters ALU d=1 every cycle -> grant alternates 01,10,01,...; wb_v=1 every cycle from the 2nd cycle on, wb_src alternating 0,1.
REQ-033 req0 d=3 granted in cycle t; req1 d=2 in t+1 -> grant=00; req1 d=2 in t+2 -> granted, wb in t+4.
REQ-034 req0 MUL d=4 in cycle t; req1 MUL held in t+1..t+3 -> grant=00; granted in t+4. With mul_ready=0, MUL is never granted.
REQ-035 req0 unit=3 or ADD with add_ready=0, req1 ALU -> only req1 granted; rr unaffected by req0.
REQ-036 reset=0 in cycle t+1 after a d=5 grant in t -> wb_v=0 at once; no wb_v in t+5 after release.

Source files
------------

// File: rtl/fu_sched_pkg.sv
// fu_sched_pkg: shared unit encoding, sizing constants and readiness helper for the issue arbiter
package fu_sched_pkg;

    typedef enum logic [1:0] {
        UNIT_ALU     = 2'd0,
        UNIT_ADD     = 2'd1,
        UNIT_MUL     = 2'd2,
        UNIT_ILLEGAL = 2'd3
    } unit_e;

    localparam int NUM_REQ   = 2;
    localparam int MAX_DELAY = 7;

    function automatic logic unit_ready(unit_e u, logic add_rdy, logic mul_rdy);
        return (u == UNIT_ALU) || (u == UNIT_ADD && add_rdy) || (u == UNIT_MUL && mul_rdy);
    endfunction

endpackage

// File: rtl/fu_issue_arbiter_if.sv
// fu_issue_arbiter_if: request, dispatch and writeback signals between the front end and the arbiter
interface fu_issue_arbiter_if;
    import fu_sched_pkg::*;

    logic [NUM_REQ-1:0]   req_v;
    logic [2*NUM_REQ-1:0] req_unit;
    logic [3*NUM_REQ-1:0] req_delay;
    logic                 add_ready;
    logic                 mul_ready;
    logic [NUM_REQ-1:0]   grant;
    logic                 issue_v;
    logic [1:0]           issue_unit;
    logic [2:0]           issue_delay;
    logic                 issue_src;
    logic                 wb_v;
    logic                 wb_src;

    modport master (
        output req_v, req_unit, req_delay, add_ready, mul_ready,
        input  grant, issue_v, issue_unit, issue_delay, issue_src, wb_v, wb_src
    );

    modport slave (
        input  req_v, req_unit, req_delay, add_ready, mul_ready,
        output grant, issue_v, issue_unit, issue_delay, issue_src, wb_v, wb_src
    );

endinterface

// File: rtl/wb_slot_tracker.sv
// wb_slot_tracker: shifting reservation table for the shared result bus; slot k means "writeback k cycles from now"
module wb_slot_tracker
    import fu_sched_pkg::*;
(
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     ins_v,
    input  logic [2:0]               ins_delay,
    input  logic                     ins_src,
    input  logic [NUM_REQ-1:0][2:0]  q_delay,
    output logic [NUM_REQ-1:0]       q_free,
    output logic                     wb_v,
    output logic                     wb_src
);
    // slot 0 is the current cycle's writeback, so it doubles as the registered wb_v/wb_src
    logic [MAX_DELAY:0] slot_v, slot_o, nxt_v, nxt_o;

    // A delay of 0 never touches the bus; otherwise the slot at that distance must be empty
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++)
            q_free[i] = (q_delay[i] == 3'd0) || !slot_v[q_delay[i]];
    end

    // Book the new grant's slot before the table advances
    always_comb begin
        nxt_v = slot_v;
        nxt_o = slot_o;
        if (ins_v && ins_delay != 3'd0) begin
            nxt_v[ins_delay] = 1'b1;
            nxt_o[ins_delay] = ins_src;
        end
    end

    // Advance one slot per cycle; reset drops every pending writeback
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            slot_v <= '0;
            slot_o <= '0;
        end else begin
            slot_v <= {1'b0, nxt_v[MAX_DELAY:1]};
            slot_o <= {1'b0, nxt_o[MAX_DELAY:1]};
        end
    end

    assign wb_v   = slot_v[0];
    assign wb_src = slot_o[0];

endmodule

// File: rtl/fu_issue_arbiter.sv
// fu_issue_arbiter: two-requester round-robin dispatch with unit readiness and result-bus slot reservation
module fu_issue_arbiter
    import fu_sched_pkg::*;
(
    input logic               clk,
    input logic               reset,
    fu_issue_arbiter_if.slave bus
);
    logic                     rr, sel, any;
    logic [2:0]               mul_cnt;
    logic [NUM_REQ-1:0]       elig, q_free;
    logic [NUM_REQ-1:0][2:0]  q_delay;
    logic [NUM_REQ-1:0][1:0]  units;

    assign q_delay = bus.req_delay;
    assign units   = bus.req_unit;

    // A requester may issue only to a legal, ready unit with its writeback slot free
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++)
            elig[i] = bus.req_v[i] && q_free[i] &&
                      unit_ready(unit_e'(units[i]), bus.add_ready, bus.mul_ready && mul_cnt == 3'd0);
    end

    // Round-robin pick among eligible requesters; all dispatch outputs forced low in reset
    always_comb begin
        any             = reset && (elig != '0);
        sel             = (&elig) ? rr : elig[1];
        bus.grant       = any ? (sel ? 2'b10 : 2'b01) : 2'b00;
        bus.issue_v     = any;
        bus.issue_unit  = any ? units[sel] : 2'b00;
        bus.issue_delay = any ? q_delay[sel] : 3'd0;
        bus.issue_src   = any && sel;
    end

    // Priority flips away from whoever was just granted; blocked cycles leave it alone
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            rr <= 1'b0;
        else if (any)
            rr <= ~sel;
    end

    // MUL stays busy until its own writeback cycle, so the next MUL lands no earlier than that
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            mul_cnt <= 3'd0;
        else if (any && units[sel] == UNIT_MUL)
            mul_cnt <= (q_delay[sel] > 3'd1) ? q_delay[sel] - 3'd1 : 3'd0;
        else if (mul_cnt != 3'd0)
            mul_cnt <= mul_cnt - 3'd1;
    end

    wb_slot_tracker u_tracker (
        .clk       (clk),
        .reset     (reset),
        .ins_v     (any),
        .ins_delay (q_delay[sel]),
        .ins_src   (sel),
        .q_delay   (q_delay),
        .q_free    (q_free),
        .wb_v      (bus.wb_v),
        .wb_src    (bus.wb_src)
    );

endmodule
